// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: computes a - b one bit per clock through a
// registered full-subtractor cell and returns the result over a valid/ack handshake.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             valid,
    input  logic             ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] diff_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bin_q;
    logic             borrow_q;
    logic             zero_q;
    logic             valid_q;
    logic             busy_q;

    logic             d_bit;
    logic             bout_bit;
    logic             last_bit;
    logic [WIDTH-1:0] sr_d;

    // Full-subtractor cell on the current LSBs plus the borrow carried from the previous bit.
    always_comb begin
        d_bit    = sa_q[0] ^ sb_q[0] ^ bin_q;
        bout_bit = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bin_q);
        sr_d     = {d_bit, sr_q[WIDTH-1:1]};
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Handshake: valid rises when the last bit is produced and stays high, with diff,
    // borrow and zero frozen, until ack is seen at a rising edge; that edge returns to
    // IDLE and any start in the same cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        sr_q    <= '0;
                        bin_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sr_q  <= sr_d;
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    bin_q <= bout_bit;
                    if (last_bit) begin
                        diff_q   <= sr_d;
                        borrow_q <= bout_bit;
                        zero_q   <= (sr_d == '0);
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (ack) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor: reset values, latency,
// arithmetic results, handshake hold/ignore behaviour and mid-run reset.
module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam int TMO   = 4 * WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
    logic             valid;
    logic             ack;

    int n_checks = 0;
    int n_errors = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero),
        .valid  (valid),
        .ack    (ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end #1 after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!valid && cyc < TMO) begin
            tick();
            cyc++;
        end
    endtask

    task automatic ack_op(input int delay);
        repeat (delay) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("valid_after_ack", {31'b0, valid}, 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] ed,
                                input logic eb, input logic ez);
        check({tag, "_valid"},  {31'b0, valid},  32'd1);
        check({tag, "_diff"},   {24'b0, diff},   {24'b0, ed});
        check({tag, "_borrow"}, {31'b0, borrow}, {31'b0, eb});
        check({tag, "_zero"},   {31'b0, zero},   {31'b0, ez});
    endtask

    task automatic run_directed(input string tag, input logic [WIDTH-1:0] av,
                                input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] ed,
                                input logic eb, input logic ez);
        int cyc;
        start_op(av, bv);
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        wait_valid(cyc);
        check({tag, "_latency"}, cyc, WIDTH);
        check_result(tag, ed, eb, ez);
        ack_op(0);
    endtask

    initial begin
        int cyc;
        int ra;
        int rb;
        logic [WIDTH-1:0] ed;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; ack = 1'b0;
        repeat (3) tick();
        check("rst_busy",   {31'b0, busy},   32'd0);
        check("rst_valid",  {31'b0, valid},  32'd0);
        check("rst_diff",   {24'b0, diff},   32'd0);
        check("rst_borrow", {31'b0, borrow}, 32'd0);
        check("rst_zero",   {31'b0, zero},   32'd0);
        rst = 1'b0;
        tick();

        // Basic op with a 20-cycle ack hold.
        start_op(8'h5A, 8'h23);
        check("hold_busy", {31'b0, busy}, 32'd1);
        wait_valid(cyc);
        check("hold_latency", cyc, WIDTH);
        for (int i = 0; i < 20; i++) begin
            check_result("hold", 8'h37, 1'b0, 1'b0);
            tick();
        end
        ack_op(0);

        run_directed("v10_20", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        run_directed("v00_ff", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
        run_directed("v77_77", 8'h77, 8'h77, 8'h00, 1'b0, 1'b1);
        run_directed("vff_00", 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);

        // Start pulses during RUN and DONE are ignored.
        start_op(8'h10, 8'h20);
        repeat (2) tick();
        start_op(8'h01, 8'h01);
        wait_valid(cyc);
        check("midrun_latency", cyc, WIDTH - 3);
        check_result("midrun", 8'hF0, 1'b1, 1'b0);
        start_op(8'h44, 8'h11);
        check_result("done_start", 8'hF0, 1'b1, 1'b0);
        tick();
        check_result("done_start2", 8'hF0, 1'b1, 1'b0);

        // ack together with start: back to IDLE, no new operation.
        ack = 1'b1; start = 1'b1; a = 8'h44; b = 8'h11;
        tick();
        ack = 1'b0; start = 1'b0;
        check("ackstart_valid", {31'b0, valid}, 32'd0);
        check("ackstart_busy",  {31'b0, busy},  32'd0);
        tick();
        check("ackstart_busy2", {31'b0, busy}, 32'd0);
        check("ackstart_diff",  {24'b0, diff}, 32'h0000_00F0);

        run_directed("v33_11", 8'h33, 8'h11, 8'h22, 1'b0, 1'b0);

        // Reset three cycles into RUN.
        start_op(8'hAB, 8'h12);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy",   {31'b0, busy},   32'd0);
        check("midrst_valid",  {31'b0, valid},  32'd0);
        check("midrst_diff",   {24'b0, diff},   32'd0);
        check("midrst_borrow", {31'b0, borrow}, 32'd0);
        check("midrst_zero",   {31'b0, zero},   32'd0);
        begin
            int rose = 0;
            for (int i = 0; i < 2 * WIDTH; i++) begin
                if (valid || busy) rose = 1;
                tick();
            end
            check("midrst_quiet", rose, 0);
        end
        run_directed("v80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0);

        // Random sweep with variable ack delay.
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            ed = WIDTH'(ra - rb);
            start_op(WIDTH'(ra), WIDTH'(rb));
            wait_valid(cyc);
            check_result("rand", ed, ra < rb, ra == rb);
            ack_op($urandom_range(0, 5));
            if (valid) begin
                check("rand_abort", {31'b0, valid}, 32'd0);
                break;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
